// File: rtl/player_life_manager.sv
// Player life state: counts down lives on accepted hits, sequences the death window,
// respawn with blinking invulnerability, and game over / restart.
module player_life_manager #(
    parameter int INIT_LIVES    = 3,
    parameter int LIVES_W       = 3,
    parameter int DEATH_FRAMES  = 30,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_SHIFT   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               hit_pulse,
    input  logic               restart,
    output logic [LIVES_W-1:0] lives,
    output logic               player_visible,
    output logic               invulnerable,
    output logic               dying,
    output logic               game_over,
    output logic               life_lost_pulse,
    output logic               respawn_pulse
);

    localparam int MAX_FRAMES = (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
    localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    localparam logic [CNT_W-1:0]   DEATH_LAST  = CNT_W'(DEATH_FRAMES - 1);
    localparam logic [CNT_W-1:0]   INVULN_LAST = CNT_W'(INVULN_FRAMES - 1);
    localparam logic [LIVES_W-1:0] LIVES_RESET = LIVES_W'(INIT_LIVES);

    typedef enum logic [1:0] {
        ALIVE,
        DYING,
        INVULN,
        GAME_OVER
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] blink_bits;
    logic             blink_on;

    // Shifting instead of indexing keeps the sprite solid when BLINK_SHIFT exceeds the counter width.
    always_comb begin
        cnt_next   = frame_cnt + 1'b1;
        blink_bits = cnt_next >> BLINK_SHIFT;
        blink_on   = ~blink_bits[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ALIVE;
            lives           <= LIVES_RESET;
            frame_cnt       <= '0;
            player_visible  <= 1'b1;
            invulnerable    <= 1'b0;
            dying           <= 1'b0;
            game_over       <= 1'b0;
            life_lost_pulse <= 1'b0;
            respawn_pulse   <= 1'b0;
        end else begin
            life_lost_pulse <= 1'b0;
            respawn_pulse   <= 1'b0;

            unique case (state)
                ALIVE: begin
                    // A startOfFrame arriving with the hit is deliberately not counted.
                    if (hit_pulse) begin
                        state           <= DYING;
                        lives           <= lives - 1'b1;
                        life_lost_pulse <= 1'b1;
                        frame_cnt       <= '0;
                        player_visible  <= 1'b0;
                        dying           <= 1'b1;
                        invulnerable    <= 1'b1;
                    end
                end

                DYING: begin
                    if (startOfFrame) begin
                        if (frame_cnt == DEATH_LAST) begin
                            frame_cnt <= '0;
                            dying     <= 1'b0;
                            if (lives == '0) begin
                                state        <= GAME_OVER;
                                invulnerable <= 1'b0;
                                game_over    <= 1'b1;
                            end else begin
                                state          <= INVULN;
                                respawn_pulse  <= 1'b1;
                                player_visible <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= cnt_next;
                        end
                    end
                end

                INVULN: begin
                    if (startOfFrame) begin
                        if (frame_cnt == INVULN_LAST) begin
                            state          <= ALIVE;
                            frame_cnt      <= '0;
                            invulnerable   <= 1'b0;
                            player_visible <= 1'b1;
                        end else begin
                            frame_cnt      <= cnt_next;
                            player_visible <= blink_on;
                        end
                    end
                end

                GAME_OVER: begin
                    if (restart) begin
                        state          <= ALIVE;
                        lives          <= LIVES_RESET;
                        frame_cnt      <= '0;
                        game_over      <= 1'b0;
                        invulnerable   <= 1'b0;
                        dying          <= 1'b0;
                        player_visible <= 1'b1;
                    end
                end

                default: begin
                    state <= ALIVE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_life_manager.sv
// Randomised and directed checks of player_life_manager against a frame-counting
// reference model of the life/respawn/game-over rules.
module tb_player_life_manager;

    localparam int INIT_LIVES    = 3;
    localparam int LIVES_W       = 3;
    localparam int DEATH_FRAMES  = 30;
    localparam int INVULN_FRAMES = 60;
    localparam int BLINK_SHIFT   = 2;

    localparam int M_ALIVE = 0;
    localparam int M_DYING = 1;
    localparam int M_INV   = 2;
    localparam int M_OVER  = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               startOfFrame = 1'b0;
    logic               hit_pulse = 1'b0;
    logic               restart = 1'b0;
    logic [LIVES_W-1:0] lives;
    logic               player_visible;
    logic               invulnerable;
    logic               dying;
    logic               game_over;
    logic               life_lost_pulse;
    logic               respawn_pulse;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode, lives and frames remaining in the current timed window.
    int m_mode;
    int m_lives;
    int m_left;
    bit m_llp;
    bit m_rsp;
    bit hit_in_frame;

    player_life_manager #(
        .INIT_LIVES(INIT_LIVES),
        .LIVES_W(LIVES_W),
        .DEATH_FRAMES(DEATH_FRAMES),
        .INVULN_FRAMES(INVULN_FRAMES),
        .BLINK_SHIFT(BLINK_SHIFT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .startOfFrame(startOfFrame),
        .hit_pulse(hit_pulse),
        .restart(restart),
        .lives(lives),
        .player_visible(player_visible),
        .invulnerable(invulnerable),
        .dying(dying),
        .game_over(game_over),
        .life_lost_pulse(life_lost_pulse),
        .respawn_pulse(respawn_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] pack_dut();
        return {lives, player_visible, invulnerable, dying, game_over, life_lost_pulse, respawn_pulse};
    endfunction

    function automatic logic [8:0] exp_vec();
        logic vis;
        int   elapsed;
        elapsed = INVULN_FRAMES - m_left;
        case (m_mode)
            M_ALIVE: vis = 1'b1;
            M_INV:   vis = (((elapsed / (1 << BLINK_SHIFT)) % 2) == 0);
            default: vis = 1'b0;
        endcase
        return {LIVES_W'(m_lives), vis, (m_mode == M_DYING || m_mode == M_INV),
                (m_mode == M_DYING), (m_mode == M_OVER), m_llp, m_rsp};
    endfunction

    task automatic model_reset();
        m_mode = M_ALIVE;
        m_lives = INIT_LIVES;
        m_left = 0;
        m_llp = 0;
        m_rsp = 0;
        hit_in_frame = 0;
    endtask

    task automatic model_step(input bit sof, input bit hit, input bit rs);
        m_llp = 0;
        m_rsp = 0;
        case (m_mode)
            M_ALIVE: if (hit) begin
                m_lives--;
                m_llp = 1;
                m_mode = M_DYING;
                m_left = DEATH_FRAMES;
            end
            M_DYING: if (sof) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_lives == 0) m_mode = M_OVER;
                    else begin
                        m_mode = M_INV;
                        m_left = INVULN_FRAMES;
                        m_rsp = 1;
                    end
                end
            end
            M_INV: if (sof) begin
                m_left--;
                if (m_left == 0) m_mode = M_ALIVE;
            end
            default: if (rs) begin
                m_mode = M_ALIVE;
                m_lives = INIT_LIVES;
            end
        endcase
    endtask

    // Inputs are applied just after a rising edge and consumed by the next one.
    task automatic drive(input bit sof, input bit hit, input bit rs);
        if (sof) hit_in_frame = 0;
        if (hit) hit_in_frame = 1;
        startOfFrame = sof;
        hit_pulse = hit;
        restart = rs;
        @(posedge clk);
        model_step(sof, hit, rs);
        #1;
        startOfFrame = 1'b0;
        hit_pulse = 1'b0;
        restart = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        vectors++;
        if (pack_dut() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_defaults: got %b expected %b", pack_dut(), exp_vec());
        end
        reset = 1'b0;
    endtask

    task automatic test_hit_respawn();
        int i;
        drive(0, 1, 0);
        vectors++;
        if (pack_dut() !== exp_vec()) begin
            miscompares++;
            $display("FAIL hit_accept: got %b expected %b", pack_dut(), exp_vec());
        end
        for (i = 0; i < 600 && m_mode != M_ALIVE; i++) begin
            if (i % 2 == 0) drive(1, 0, 0);
            else drive(0, ($urandom_range(0, 2) == 0), 0);
            vectors++;
            if (pack_dut() !== exp_vec()) begin
                miscompares++;
                $display("FAIL hit_respawn cycle %0d: got %b expected %b", i, pack_dut(), exp_vec());
            end
        end
        vectors++;
        if (invulnerable !== 1'b0 || lives !== LIVES_W'(INIT_LIVES - 1)) begin
            miscompares++;
            $display("FAIL respawn_done: invulnerable=%b lives=%0d expected 0 and %0d",
                     invulnerable, lives, INIT_LIVES - 1);
        end
    endtask

    task automatic test_game_over();
        int i;
        for (i = 0; i < 3000 && m_mode != M_OVER; i++) begin
            if (i % 2 == 0) drive(1, 0, 0);
            else drive(0, (m_mode == M_ALIVE) || ($urandom_range(0, 3) == 0), 0);
            vectors++;
            if (pack_dut() !== exp_vec()) begin
                miscompares++;
                $display("FAIL game_over_seq cycle %0d: got %b expected %b", i, pack_dut(), exp_vec());
            end
        end
        vectors++;
        if (game_over !== 1'b1 || lives !== '0) begin
            miscompares++;
            $display("FAIL game_over_reached: game_over=%b lives=%0d expected 1 and 0", game_over, lives);
        end
        for (i = 0; i < 6; i++) begin
            drive(i % 2 == 0, i % 2 == 1, 0);
            vectors++;
            if (pack_dut() !== exp_vec()) begin
                miscompares++;
                $display("FAIL game_over_hit_ignored: got %b expected %b", pack_dut(), exp_vec());
            end
        end
    endtask

    task automatic test_restart();
        drive(0, 0, 1);
        vectors++;
        if (pack_dut() !== exp_vec() || game_over !== 1'b0 || lives !== LIVES_W'(INIT_LIVES)) begin
            miscompares++;
            $display("FAIL restart_from_over: got %b expected %b", pack_dut(), exp_vec());
        end
        drive(0, 0, 1);
        vectors++;
        if (pack_dut() !== exp_vec()) begin
            miscompares++;
            $display("FAIL restart_in_alive: got %b expected %b", pack_dut(), exp_vec());
        end
        drive(0, 1, 0);
        drive(1, 0, 1);
        drive(0, 0, 1);
        vectors++;
        if (pack_dut() !== exp_vec()) begin
            miscompares++;
            $display("FAIL restart_in_dying: got %b expected %b", pack_dut(), exp_vec());
        end
        reset = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (pack_dut() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_mid_dying: got %b expected %b", pack_dut(), exp_vec());
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_coincident();
        int i;
        int sof_count;
        int sof_at_respawn;
        sof_count = 0;
        sof_at_respawn = -1;
        drive(1, 1, 0);
        vectors++;
        if (pack_dut() !== exp_vec()) begin
            miscompares++;
            $display("FAIL coincident_hit: got %b expected %b", pack_dut(), exp_vec());
        end
        for (i = 0; i < 200 && sof_at_respawn < 0; i++) begin
            if (i % 2 == 0) begin
                drive(1, 0, 0);
                sof_count++;
            end else drive(0, 0, 0);
            if (respawn_pulse === 1'b1) sof_at_respawn = sof_count;
            vectors++;
            if (pack_dut() !== exp_vec()) begin
                miscompares++;
                $display("FAIL coincident_window cycle %0d: got %b expected %b", i, pack_dut(), exp_vec());
            end
        end
        vectors++;
        if (sof_at_respawn != DEATH_FRAMES) begin
            miscompares++;
            $display("FAIL coincident_exit_frames: got %0d expected %0d", sof_at_respawn, DEATH_FRAMES);
        end
    endtask

    task automatic test_random();
        bit sof;
        bit hit;
        bit rs;
        for (int i = 0; i < 4000; i++) begin
            sof = ($urandom_range(0, 3) == 0);
            hit = ($urandom_range(0, 4) == 0) && (sof || !hit_in_frame);
            rs = ($urandom_range(0, 9) == 0);
            drive(sof, hit, rs);
            vectors++;
            if (pack_dut() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cycle %0d: got %b expected %b", i, pack_dut(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hit_respawn();
        test_game_over();
        test_restart();
        test_coincident();
        test_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
